// File: rtl/dm_pkg.sv
// Shared definitions for the data memory with store tracing:
// default geometry, controller states and the trace entry layout.
package dm_pkg;

    localparam int DM_ADDR_W = 12;
    localparam int NUM_LANES = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dm_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_fifo.sv
// Store-trace FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable. A push while full is accepted only if a pop frees
// the head slot on the same edge; otherwise it is reported as a drop.
//
// Handshake: an entry leaves on a rising edge where valid=1 and ready=1;
// head is held stable while valid=1 and ready=0; ready is ignored while
// the FIFO is empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             drop,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic empty, full, pop, accept;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop    = !empty && ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign valid  = !empty;
    // Head reads as zero when there is nothing to present.
    assign head   = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    // Next pointer values: advance on accepted push / pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers, cleared to empty by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/dm_trace.sv
// Word-addressed data memory with byte-lane stores, a post-reset clearing
// sweep, and a trace FIFO recording every committed store.
module dm_trace
    import dm_pkg::*;
#(
    parameter int ADDR_W      = DM_ADDR_W,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        init_busy,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        trace_overflow
);

    localparam int WORDS = 1 << ADDR_W;

    dm_state_e         state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              overflow_q, overflow_d;
    logic [31:0]       mem_q [WORDS];

    logic [ADDR_W-1:0] idx;
    logic              busy;
    logic              store;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic              drop;
    trace_entry_t      push_entry;
    logic [TRACE_W-1:0] head_vec;
    trace_entry_t      head_entry;

    // Address bits outside the word index are ignored, so addresses alias.
    assign idx      = m_data_addr[ADDR_W+1:2];
    assign busy     = (state_q == CLEAR);
    assign store    = (|m_data_byteen) && !busy;
    assign cur_word = mem_q[idx];

    // Replace only the enabled byte lanes of the current word.
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
        end
    end

    // Controller: sweep every word to zero once, then run until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == {ADDR_W{1'b1}}) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Memory array: clearing sweep wins, otherwise commit the merged store.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (store) begin
            mem_q[idx] <= merged;
        end
    end

    assign overflow_d = overflow_q | drop;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign push_entry.pc   = m_inst_addr;
    assign push_entry.addr = {m_data_addr[31:2], 2'b00};
    assign push_entry.data = merged;

    trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (store),
        .push_data (push_entry),
        .drop      (drop),
        .valid     (trace_valid),
        .ready     (trace_ready),
        .head      (head_vec)
    );

    assign head_entry     = head_vec;
    assign trace_pc       = head_entry.pc;
    assign trace_addr     = head_entry.addr;
    assign trace_data     = head_entry.data;
    assign trace_overflow = overflow_q;

    assign init_busy    = busy;
    assign m_data_rdata = busy ? 32'h0 : cur_word;

endmodule

// File: tb/tb_dm_trace.sv
// Directed bench for dm_trace with ADDR_W=4, TRACE_DEPTH=8.
module tb_dm_trace;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        init_busy;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        trace_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] pc;
        logic [31:0] exp_before;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    dm_trace #(
        .ADDR_W      (4),
        .TRACE_DEPTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .m_inst_addr    (m_inst_addr),
        .m_data_rdata   (m_data_rdata),
        .init_busy      (init_busy),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_overflow (trace_overflow)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] pc);
        m_data_addr   = addr;
        m_data_wdata  = wdata;
        m_data_byteen = be;
        m_inst_addr   = pc;
        tick();
        m_data_byteen = 4'b0;
    endtask

    task automatic read_word(input string name, input logic [31:0] addr, input logic [31:0] exp);
        m_data_addr = addr;
        #1;
        check(name, {64'h0, m_data_rdata}, {64'h0, exp});
        tick();
    endtask

    // Count cycles with init_busy=1 after reset release, bounded.
    task automatic count_busy(output int cyc);
        cyc = 0;
        while (init_busy && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    // Pop entries with ready=1 and compare them against the expected queue.
    task automatic drain(input int exp_n);
        int n;
        logic [95:0] e;
        n = 0;
        trace_ready = 1'b1;
        #1;
        while (trace_valid && n < 64) begin
            if (exp_q.size() == 0) e = 96'hx;
            else e = exp_q.pop_front();
            check("trace_entry", {trace_pc, trace_addr, trace_data}, e);
            tick();
            n++;
        end
        trace_ready = 1'b0;
        check("drain_count", 96'(n), 96'(exp_n));
        check("valid_after_drain", {95'h0, trace_valid}, 96'h0);
    endtask

    initial begin
        int cyc;

        vecs[0] = '{32'h08, 32'hAABBCCDD, 4'b1111, 32'h100, 32'h0,        32'hAABBCCDD};
        vecs[1] = '{32'h09, 32'h0000EE00, 4'b0010, 32'h104, 32'hAABBCCDD, 32'hAABBEEDD};
        vecs[2] = '{32'h40, 32'h11223344, 4'b1111, 32'h108, 32'h0,        32'h11223344};
        vecs[3] = '{32'h00, 32'h99000000, 4'b1000, 32'h10C, 32'h11223344, 32'h99223344};
        vecs[4] = '{32'h3C, 32'hDEADBEEF, 4'b0101, 32'h110, 32'h0,        32'h00AD00EF};
        vecs[5] = '{32'h7E, 32'h12345678, 4'b1010, 32'h114, 32'h00AD00EF, 32'h12AD56EF};

        reset         = 1'b0;
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = '0;
        m_inst_addr   = '0;
        trace_ready   = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_busy",     {95'h0, init_busy}, 96'h1);
        check("rst_valid",    {95'h0, trace_valid}, 96'h0);
        check("rst_overflow", {95'h0, trace_overflow}, 96'h0);
        check("rst_fields",   {trace_pc, trace_addr, trace_data}, 96'h0);
        check("rst_rdata",    {64'h0, m_data_rdata}, 96'h0);

        // Release; a store to already-cleared word 0 mid-sweep must be dropped
        reset = 1'b1;
        cyc = 0;
        while (init_busy && cyc < 64) begin
            if (cyc == 3) begin
                m_data_addr   = 32'h0;
                m_data_wdata  = 32'hFFFFFFFF;
                m_data_byteen = 4'hF;
                m_inst_addr   = 32'h0BAD;
            end else begin
                m_data_byteen = 4'h0;
            end
            tick();
            cyc++;
        end
        m_data_byteen = 4'h0;
        check("clear_cycles", 96'(cyc), 96'd16);
        check("clear_no_trace", {95'h0, trace_valid}, 96'h0);
        for (int i = 0; i < 16; i++) read_word("cleared_word", 32'(i * 4), 32'h0);

        // Table-driven stores with ready held low
        check("valid_before_store", {95'h0, trace_valid}, 96'h0);
        for (int i = 0; i < 6; i++) begin
            m_data_addr   = vecs[i].addr;
            m_data_wdata  = vecs[i].wdata;
            m_data_byteen = vecs[i].be;
            m_inst_addr   = vecs[i].pc;
            #1;
            check("same_cycle_read", {64'h0, m_data_rdata}, {64'h0, vecs[i].exp_before});
            tick();
            m_data_byteen = 4'b0;
            m_data_addr   = vecs[i].addr & 32'h3C;
            #1;
            check("store_readback", {64'h0, m_data_rdata}, {64'h0, vecs[i].exp_word});
            exp_q.push_back({vecs[i].pc, vecs[i].addr & 32'hFFFFFFFC, vecs[i].exp_word});
            if (i == 0) check("push_to_valid", {95'h0, trace_valid}, 96'h1);
        end
        check("head_stable", {trace_pc, trace_addr, trace_data},
              {32'h100, 32'h8, 32'hAABBCCDD});
        drain(6);

        // ready with empty FIFO has no effect
        trace_ready = 1'b1;
        repeat (2) tick();
        check("empty_ready_valid", {95'h0, trace_valid}, 96'h0);
        check("empty_ready_ovf",   {95'h0, trace_overflow}, 96'h0);
        trace_ready = 1'b0;

        // Overflow: 9 stores into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            do_store(32'(i * 4), 32'h1000 + 32'(i), 4'hF, 32'h200 + 32'(i * 4));
            if (i < 8) exp_q.push_back({32'h200 + 32'(i * 4), 32'(i * 4), 32'h1000 + 32'(i)});
            if (i == 7) check("full_no_ovf", {95'h0, trace_overflow}, 96'h0);
        end
        check("overflow_set", {95'h0, trace_overflow}, 96'h1);
        for (int i = 0; i < 9; i++) read_word("ovf_mem", 32'(i * 4), 32'h1000 + 32'(i));
        drain(8);
        check("overflow_sticky", {95'h0, trace_overflow}, 96'h1);

        // Reset mid-CLEAR with a store issued during the sweep
        do_store(32'h20, 32'h55, 4'hF, 32'h280);
        check("pre_reset_valid", {95'h0, trace_valid}, 96'h1);
        reset = 1'b0;
        #1;
        check("async_busy",   {95'h0, init_busy}, 96'h1);
        check("async_valid",  {95'h0, trace_valid}, 96'h0);
        check("async_ovf",    {95'h0, trace_overflow}, 96'h0);
        check("async_fields", {trace_pc, trace_addr, trace_data}, 96'h0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                m_data_addr   = 32'h4;
                m_data_wdata  = 32'hCAFEF00D;
                m_data_byteen = 4'hF;
                m_inst_addr   = 32'h2C0;
            end else begin
                m_data_byteen = 4'h0;
            end
            tick();
        end
        m_data_byteen = 4'h0;
        check("mid_clear_busy",  {95'h0, init_busy}, 96'h1);
        check("mid_clear_valid", {95'h0, trace_valid}, 96'h0);
        reset = 1'b0;
        #1;
        tick();
        reset = 1'b1;
        count_busy(cyc);
        check("restart_cycles", 96'(cyc), 96'd16);
        check("restart_no_trace", {95'h0, trace_valid}, 96'h0);
        read_word("discarded_store", 32'h4, 32'h0);
        read_word("resweep_word8",   32'h20, 32'h0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) begin
            do_store(32'(i * 4), 32'h3000 + 32'(i), 4'hF, 32'h300 + 32'(i * 4));
            exp_q.push_back({32'h300 + 32'(i * 4), 32'(i * 4), 32'h3000 + 32'(i)});
        end
        check("full_ovf_clear", {95'h0, trace_overflow}, 96'h0);
        trace_ready   = 1'b1;
        m_data_addr   = 32'h30;
        m_data_wdata  = 32'h3008;
        m_data_byteen = 4'hF;
        m_inst_addr   = 32'h320;
        #1;
        check("popped_head", {64'h0, trace_data}, {64'h0, 32'h3000});
        tick();
        m_data_byteen = 4'h0;
        trace_ready   = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({32'h320, 32'h30, 32'h3008});
        check("pop_push_no_ovf", {95'h0, trace_overflow}, 96'h0);
        drain(8);
        check("pop_push_ovf_end", {95'h0, trace_overflow}, 96'h0);
        read_word("pop_push_mem", 32'h30, 32'h3008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
